// File: rtl/seg_update_master.sv
// -----------------------------------------------------------------------------
// seg_update_master
//
// Second bus master that pushes a packed multi-digit value into the
// memory-mapped seven-segment display peripheral, one byte-wide write per
// digit, to the register window BASE_ADDR .. BASE_ADDR+NUM_DIGITS-1.
//
// Parameters:
//   BASE_ADDR    address of the digit-0 register in the display peripheral
//   NUM_DIGITS   digit registers written per update (1..4)
//
// Ports:
//   CLK           system clock, rising edge
//   RESET         synchronous, active-high reset
//   VALUE_IN      packed digits, digit i = VALUE_IN[4i+3:4i]
//   VALUE_VALID   requester has a value to display (held until VALUE_READY)
//   VALUE_READY   controller can accept a value (IDLE only)
//   BUS_REQ       request for bus ownership (REQ and WRITE)
//   BUS_GNT       bus grant from the processor-side arbiter, may drop any cycle
//   BUS_ADDR      write address, 8'h00 outside WRITE
//   BUS_DATA_OUT  write data {4'h0, digit}, 8'h00 outside WRITE
//   BUS_WE        write strobe
//   BUS_DRIVE     tristate enable for the shared data bus, equals BUS_WE
//   BUSY          an update is in progress
//   DONE          one-cycle pulse after the last digit has been written
// -----------------------------------------------------------------------------
module seg_update_master #(
    parameter logic [7:0]  BASE_ADDR  = 8'hD0,
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [4*NUM_DIGITS-1:0] VALUE_IN,
    input  logic                    VALUE_VALID,
    output logic                    VALUE_READY,
    output logic                    BUS_REQ,
    input  logic                    BUS_GNT,
    output logic [7:0]              BUS_ADDR,
    output logic [7:0]              BUS_DATA_OUT,
    output logic                    BUS_WE,
    output logic                    BUS_DRIVE,
    output logic                    BUSY,
    output logic                    DONE
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WRITE  = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [1:0] LAST_IDX = 2'(NUM_DIGITS - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [1:0]              r_idx;
    logic [4*NUM_DIGITS-1:0] r_value;

    logic                    w_capture;
    logic                    w_advance;
    logic [3:0]              w_digits [4];
    logic [3:0]              w_digit;

    // Fixed four-entry digit view so the index mux never selects past the
    // captured value when NUM_DIGITS < 4; unused slots read as zero.
    for (genvar g = 0; g < 4; g++) begin : g_digit
        if (g < int'(NUM_DIGITS)) begin : g_used
            assign w_digits[g] = r_value[4*g +: 4];
        end else begin : g_unused
            assign w_digits[g] = '0;
        end
    end

    assign w_digit = w_digits[r_idx];

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Captured value and digit index
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_value <= '0;
            r_idx   <= '0;
        end else if (w_capture) begin
            r_value <= VALUE_IN;
            r_idx   <= '0;
        end else if (w_advance) begin
            r_idx   <= r_idx + 2'd1;
        end
    end

    // Next-state and outputs
    always_comb begin
        w_state_nxt  = r_state;
        w_capture    = 1'b0;
        w_advance    = 1'b0;
        VALUE_READY  = 1'b0;
        BUS_REQ      = 1'b0;
        BUS_ADDR     = '0;
        BUS_DATA_OUT = '0;
        BUS_WE       = 1'b0;
        BUS_DRIVE    = 1'b0;
        BUSY         = 1'b1;
        DONE         = 1'b0;

        case (r_state)
            IDLE: begin
                VALUE_READY = 1'b1;
                BUSY        = 1'b0;
                if (VALUE_VALID) begin
                    w_capture   = 1'b1;
                    w_state_nxt = REQ;
                end
            end

            REQ: begin
                BUS_REQ = 1'b1;
                if (BUS_GNT) begin
                    w_state_nxt = WRITE;
                end
            end

            WRITE: begin
                BUS_REQ      = 1'b1;
                BUS_ADDR     = BASE_ADDR + {6'b0, r_idx};
                BUS_DATA_OUT = {4'h0, w_digit};
                // Reset wins over a write on the same edge, so the strobe is
                // withheld while RESET is high and no digit lands mid-reset.
                BUS_WE       = BUS_GNT & ~RESET;
                BUS_DRIVE    = BUS_GNT & ~RESET;
                if (BUS_GNT) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = FINISH;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end

            FINISH: begin
                DONE        = 1'b1;
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_seg_update_master.sv
// -----------------------------------------------------------------------------
// tb_seg_update_master
//
// Bench for seg_update_master: a four-digit instance at 8'hD0 and a two-digit
// instance at 8'hE0, each with a peripheral register model and a queue of
// expected {addr,data} writes consumed as strobes appear on the bus.
// -----------------------------------------------------------------------------
module tb_seg_update_master;

    localparam int BASE  = 'hD0;
    localparam int BASE2 = 'hE0;

    logic        clk = 1'b0;
    logic        rst;

    logic [15:0] value_in;
    logic        value_valid;
    logic        value_ready;
    logic        bus_req;
    logic        bus_gnt;
    logic [7:0]  bus_addr;
    logic [7:0]  bus_data;
    logic        bus_we;
    logic        bus_drive;
    logic        busy;
    logic        done;

    logic [7:0]  value_in2;
    logic        value_valid2;
    logic        value_ready2;
    logic        bus_req2;
    logic        bus_gnt2;
    logic [7:0]  bus_addr2;
    logic [7:0]  bus_data2;
    logic        bus_we2;
    logic        bus_drive2;
    logic        busy2;
    logic        done2;

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          mon_en   = 1'b0;

    logic [15:0] exp_q [$];
    logic [15:0] exp_q2 [$];
    logic [15:0] exp_w;
    logic [15:0] exp_w2;
    logic [7:0]  mem  [256];
    logic [7:0]  mem2 [256];
    int          wr_count  = 0;
    int          wr_count2 = 0;

    always #5 clk = ~clk;

    seg_update_master #(
        .BASE_ADDR  (8'hD0),
        .NUM_DIGITS (4)
    ) dut (
        .CLK          (clk),
        .RESET        (rst),
        .VALUE_IN     (value_in),
        .VALUE_VALID  (value_valid),
        .VALUE_READY  (value_ready),
        .BUS_REQ      (bus_req),
        .BUS_GNT      (bus_gnt),
        .BUS_ADDR     (bus_addr),
        .BUS_DATA_OUT (bus_data),
        .BUS_WE       (bus_we),
        .BUS_DRIVE    (bus_drive),
        .BUSY         (busy),
        .DONE         (done)
    );

    seg_update_master #(
        .BASE_ADDR  (8'hE0),
        .NUM_DIGITS (2)
    ) dut2 (
        .CLK          (clk),
        .RESET        (rst),
        .VALUE_IN     (value_in2),
        .VALUE_VALID  (value_valid2),
        .VALUE_READY  (value_ready2),
        .BUS_REQ      (bus_req2),
        .BUS_GNT      (bus_gnt2),
        .BUS_ADDR     (bus_addr2),
        .BUS_DATA_OUT (bus_data2),
        .BUS_WE       (bus_we2),
        .BUS_DRIVE    (bus_drive2),
        .BUSY         (busy2),
        .DONE         (done2)
    );

    // Display peripheral register models
    always @(posedge clk) begin
        if (bus_we === 1'b1) begin
            mem[bus_addr] <= bus_data;
            wr_count      <= wr_count + 1;
        end
        if (bus_we2 === 1'b1) begin
            mem2[bus_addr2] <= bus_data2;
            wr_count2       <= wr_count2 + 1;
        end
    end

    // Bus monitor / scoreboard, four-digit instance
    always @(negedge clk) begin
        if (mon_en) begin
            n_checks++;
            if (bus_drive !== bus_we) begin
                n_fail++;
                $display("FAIL drive_eq_we: BUS_DRIVE=%b, required BUS_WE=%b", bus_drive, bus_we);
            end
            if (bus_we === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: addr=%h data=%h, required no write", bus_addr, bus_data);
                end else begin
                    exp_w = exp_q.pop_front();
                    if ({bus_addr, bus_data} !== exp_w) begin
                        n_fail++;
                        $display("FAIL write_order: addr/data=%h, required %h", {bus_addr, bus_data}, exp_w);
                    end
                end
            end
            if (bus_req === 1'b0) begin
                n_checks++;
                if ({bus_addr, bus_data} !== 16'h0000) begin
                    n_fail++;
                    $display("FAIL idle_bus_zero: addr/data=%h, required 0000", {bus_addr, bus_data});
                end
            end
        end
    end

    // Bus monitor / scoreboard, two-digit instance
    always @(negedge clk) begin
        if (mon_en) begin
            n_checks++;
            if (bus_drive2 !== bus_we2) begin
                n_fail++;
                $display("FAIL drive_eq_we2: BUS_DRIVE=%b, required BUS_WE=%b", bus_drive2, bus_we2);
            end
            if (bus_we2 === 1'b1) begin
                n_checks++;
                if (exp_q2.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write2: addr=%h data=%h, required no write", bus_addr2, bus_data2);
                end else begin
                    exp_w2 = exp_q2.pop_front();
                    if ({bus_addr2, bus_data2} !== exp_w2) begin
                        n_fail++;
                        $display("FAIL write_order2: addr/data=%h, required %h", {bus_addr2, bus_data2}, exp_w2);
                    end
                end
            end
        end
    end

    task automatic push_exp(input logic [15:0] v);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({8'(BASE + i), 4'h0, v[4*i +: 4]});
        end
    endtask

    // Waits for READY, presents v for exactly one capture edge.
    task automatic send_value(input logic [15:0] v, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (value_ready === 1'b1) ok = 1'b1;
        end
        if (ok) begin
            value_in    = v;
            value_valid = 1'b1;
            push_exp(v);
            @(posedge clk);
            #1;
            value_valid = 1'b0;
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (done === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic [21:0] obs;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        obs = {value_ready, bus_req, bus_we, bus_drive, busy, done, bus_addr, bus_data};
        n_checks++;
        if (obs !== {6'b100000, 16'h0000}) begin
            n_fail++;
            $display("FAIL reset_outputs: %b, required %b", obs, {6'b100000, 16'h0000});
        end
        obs = {value_ready2, bus_req2, bus_we2, bus_drive2, busy2, done2, bus_addr2, bus_data2};
        n_checks++;
        if (obs !== {6'b100000, 16'h0000}) begin
            n_fail++;
            $display("FAIL reset_outputs2: %b, required %b", obs, {6'b100000, 16'h0000});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        obs = {value_ready, bus_req, bus_we, bus_drive, busy, done, bus_addr, bus_data};
        n_checks++;
        if (obs !== {6'b100000, 16'h0000}) begin
            n_fail++;
            $display("FAIL reset_release: %b, required %b", obs, {6'b100000, 16'h0000});
        end
    endtask

    task automatic test_single();
        bit          ok;
        int          base;
        logic [3:0]  pat;
        logic [27:0] pats;
        logic [15:0] v;
        v    = 16'h1234;
        // {BUS_REQ, BUS_WE, DONE, VALUE_READY} for the cycles after E0..E6
        pats = {4'b1000, 4'b1100, 4'b1100, 4'b1100, 4'b1100, 4'b0010, 4'b0001};
        bus_gnt = 1'b1;
        base = wr_count;
        send_value(v, ok);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ready: VALUE_READY never 1, required 1");
        end
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            pat = {bus_req, bus_we, done, value_ready};
            n_checks++;
            if (pat !== pats[4*(6-c) +: 4]) begin
                n_fail++;
                $display("FAIL single_timing[%0d]: req/we/done/ready=%b, required %b", c, pat, pats[4*(6-c) +: 4]);
            end
        end
        n_checks++;
        if (wr_count - base !== 4) begin
            n_fail++;
            $display("FAIL single_count: %0d writes, required 4", wr_count - base);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (mem[BASE + i] !== {4'h0, v[4*i +: 4]}) begin
                n_fail++;
                $display("FAIL single_readback D%0d: %h, required %h", i, mem[BASE + i], {4'h0, v[4*i +: 4]});
            end
        end
    endtask

    task automatic test_grant_delay();
        bit          ok;
        int          base;
        logic [15:0] v;
        v = 16'h5678;
        bus_gnt = 1'b0;
        base = wr_count;
        send_value(v, ok);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if ({bus_req, bus_we, bus_drive} !== 3'b100) begin
                n_fail++;
                $display("FAIL gdelay_wait[%0d]: req/we/drive=%b, required 100", c, {bus_req, bus_we, bus_drive});
            end
        end
        @(posedge clk);
        #1;
        bus_gnt = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus_req, bus_we} !== 2'b10) begin
            n_fail++;
            $display("FAIL gdelay_rise_cycle: req/we=%b, required 10", {bus_req, bus_we});
        end
        @(negedge clk);
        n_checks++;
        if ({bus_we, bus_addr} !== {1'b1, 8'hD0}) begin
            n_fail++;
            $display("FAIL gdelay_first_write: we/addr=%b/%h, required 1/d0", bus_we, bus_addr);
        end
        wait_done(ok);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL gdelay_done: DONE not seen, required pulse");
        end
        n_checks++;
        if (wr_count - base !== 4) begin
            n_fail++;
            $display("FAIL gdelay_count: %0d writes, required 4", wr_count - base);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (mem[BASE + i] !== {4'h0, v[4*i +: 4]}) begin
                n_fail++;
                $display("FAIL gdelay_readback D%0d: %h, required %h", i, mem[BASE + i], {4'h0, v[4*i +: 4]});
            end
        end
    endtask

    task automatic test_preempt();
        bit          ok;
        int          base;
        logic [15:0] v;
        v = 16'hABCD;
        bus_gnt = 1'b1;
        base = wr_count;
        send_value(v, ok);
        repeat (3) @(posedge clk);
        #1;
        bus_gnt = 1'b0;
        n_checks++;
        if (wr_count - base !== 2) begin
            n_fail++;
            $display("FAIL preempt_before_gap: %0d writes, required 2", wr_count - base);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if ({bus_req, bus_we, bus_drive} !== 3'b100) begin
                n_fail++;
                $display("FAIL preempt_gap[%0d]: req/we/drive=%b, required 100", c, {bus_req, bus_we, bus_drive});
            end
        end
        @(posedge clk);
        #1;
        bus_gnt = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus_we, bus_addr, bus_data} !== {1'b1, 8'hD2, 8'h0B}) begin
            n_fail++;
            $display("FAIL preempt_resume: we/addr/data=%b/%h/%h, required 1/d2/0b", bus_we, bus_addr, bus_data);
        end
        wait_done(ok);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL preempt_done: DONE not seen, required pulse");
        end
        n_checks++;
        if (wr_count - base !== 4) begin
            n_fail++;
            $display("FAIL preempt_count: %0d writes, required 4", wr_count - base);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (mem[BASE + i] !== {4'h0, v[4*i +: 4]}) begin
                n_fail++;
                $display("FAIL preempt_readback D%0d: %h, required %h", i, mem[BASE + i], {4'h0, v[4*i +: 4]});
            end
        end
    endtask

    task automatic test_busy_reject();
        bit ok;
        bit got;
        int base;
        bus_gnt = 1'b1;
        base = wr_count;
        send_value(16'h1111, ok);
        value_in    = 16'h5555;
        value_valid = 1'b1;
        push_exp(16'h5555);
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            n_checks++;
            if (value_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL busy_ready_low[%0d]: VALUE_READY=%b, required 0", c, value_ready);
            end
            if (done === 1'b1) got = 1'b1;
        end
        n_checks++;
        if (got !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_done: DONE not seen, required pulse");
        end
        n_checks++;
        if (wr_count - base !== 4) begin
            n_fail++;
            $display("FAIL busy_count_first: %0d writes, required 4", wr_count - base);
        end
        @(negedge clk);
        n_checks++;
        if (value_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_idle_ready: VALUE_READY=%b, required 1", value_ready);
        end
        @(posedge clk);
        #1;
        value_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_second_accept: BUSY=%b, required 1", busy);
        end
        wait_done(ok);
        n_checks++;
        if (wr_count - base !== 8) begin
            n_fail++;
            $display("FAIL busy_count_total: %0d writes, required 8", wr_count - base);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (mem[BASE + i] !== 8'h05) begin
                n_fail++;
                $display("FAIL busy_readback D%0d: %h, required 05", i, mem[BASE + i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit          ok;
        int          base;
        logic [21:0] obs;
        logic [15:0] v;
        bus_gnt = 1'b1;
        base = wr_count;
        send_value(16'h4321, ok);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        obs = {value_ready, bus_req, bus_we, bus_drive, busy, done, bus_addr, bus_data};
        n_checks++;
        if (obs !== {6'b100000, 16'h0000}) begin
            n_fail++;
            $display("FAIL midreset_outputs: %b, required %b", obs, {6'b100000, 16'h0000});
        end
        n_checks++;
        if (wr_count - base !== 2) begin
            n_fail++;
            $display("FAIL midreset_count: %0d writes, required 2", wr_count - base);
        end
        n_checks++;
        if (exp_q.size() !== 2) begin
            n_fail++;
            $display("FAIL midreset_pending: %0d writes outstanding, required 2", exp_q.size());
        end
        exp_q.delete();
        n_checks++;
        if ({mem[BASE + 2], mem[BASE + 3]} !== 16'h0505) begin
            n_fail++;
            $display("FAIL midreset_d2d3: %h, required 0505", {mem[BASE + 2], mem[BASE + 3]});
        end
        v = 16'h9876;
        base = wr_count;
        send_value(v, ok);
        wait_done(ok);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_next_done: DONE not seen, required pulse");
        end
        n_checks++;
        if (wr_count - base !== 4) begin
            n_fail++;
            $display("FAIL midreset_next_count: %0d writes, required 4", wr_count - base);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (mem[BASE + i] !== {4'h0, v[4*i +: 4]}) begin
                n_fail++;
                $display("FAIL midreset_readback D%0d: %h, required %h", i, mem[BASE + i], {4'h0, v[4*i +: 4]});
            end
        end
    endtask

    task automatic test_two_digit();
        bit          ok;
        int          base;
        logic [3:0]  pat;
        logic [19:0] pats;
        pats = {4'b1000, 4'b1100, 4'b1100, 4'b0010, 4'b0001};
        bus_gnt2 = 1'b1;
        base = wr_count2;
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (value_ready2 === 1'b1) ok = 1'b1;
        end
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL two_ready: VALUE_READY never 1, required 1");
        end
        value_in2    = 8'h7F;
        value_valid2 = 1'b1;
        exp_q2.push_back({8'(BASE2), 8'h0F});
        exp_q2.push_back({8'(BASE2 + 1), 8'h07});
        @(posedge clk);
        #1;
        value_valid2 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            pat = {bus_req2, bus_we2, done2, value_ready2};
            n_checks++;
            if (pat !== pats[4*(4-c) +: 4]) begin
                n_fail++;
                $display("FAIL two_timing[%0d]: req/we/done/ready=%b, required %b", c, pat, pats[4*(4-c) +: 4]);
            end
        end
        n_checks++;
        if (wr_count2 - base !== 2) begin
            n_fail++;
            $display("FAIL two_count: %0d writes, required 2", wr_count2 - base);
        end
        n_checks++;
        if ({mem2[BASE2], mem2[BASE2 + 1], mem2[BASE2 + 2]} !== 24'h0F0700) begin
            n_fail++;
            $display("FAIL two_readback: %h, required 0f0700", {mem2[BASE2], mem2[BASE2 + 1], mem2[BASE2 + 2]});
        end
        n_checks++;
        if (exp_q2.size() !== 0) begin
            n_fail++;
            $display("FAIL two_pending: %0d writes outstanding, required 0", exp_q2.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]  = 8'h00;
            mem2[i] = 8'h00;
        end
        rst          = 1'b1;
        value_in     = '0;
        value_valid  = 1'b0;
        bus_gnt      = 1'b0;
        value_in2    = '0;
        value_valid2 = 1'b0;
        bus_gnt2     = 1'b0;

        test_reset();
        mon_en = 1'b1;
        test_single();
        test_grant_delay();
        test_preempt();
        test_busy_reject();
        test_reset_mid();
        test_two_digit();

        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++;
            $display("FAIL final_pending: %0d writes outstanding, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
